shot_controller: RTL and testbench

- Initiator side of the shot-scoring interface; sits between player input (switches plus debounced Fire pulse) and the hit/near-miss scoring logic.
- Latches a guessed coordinate and bomb size, then drives X, Y, Big, ScoreThis and Wrong to the scorer for exactly one cycle.
- Collects the Hit/NearMiss/Miss response, maintains the already-fired map, shot and big-bomb budgets and hit count, and declares game over.

---
 rtl/shot_controller.sv | 168 ++++++++++++++++
 tb/tb_shot_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// Shot-scoring initiator: latches a player guess, issues a one-cycle scoring request,
// and tracks the fired map, shot/big-bomb budgets, hit count and game-over status.
//
// state | meaning
// IDLE  | waiting for a Fire pulse
// SCORE | request presented to the scorer for one cycle, response sampled
// OVER  | game finished, held until reset
module shot_controller #(
    parameter int  MAX_SHOTS   = 20,
    parameter int  MAX_BIG     = 3,
    parameter int  HITS_TO_WIN = 5,
    localparam int SW          = $clog2(MAX_SHOTS + 1),
    localparam int BW          = $clog2(MAX_BIG + 1),
    localparam int HW          = $clog2(HITS_TO_WIN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    X_in,
    input  logic [3:0]    Y_in,
    input  logic          BigReq,
    input  logic          Fire,
    input  logic          Hit,
    input  logic          NearMiss,
    input  logic          Miss,
    output logic [3:0]    X,
    output logic [3:0]    Y,
    output logic          Big,
    output logic          ScoreThis,
    output logic          Wrong,
    output logic [SW-1:0] ShotsLeft,
    output logic [BW-1:0] BigLeft,
    output logic [HW-1:0] HitCount,
    output logic [1:0]    Result,
    output logic          GameOver,
    output logic          Win
);

    typedef enum logic [1:0] {IDLE, SCORE, OVER} state_t;

    state_t        state_q, state_d;
    logic [3:0]    x_q, x_d, y_q, y_d;
    logic          big_q, big_d;
    logic [99:0]   map_q, map_d;
    logic [SW-1:0] shots_q, shots_d;
    logic [BW-1:0] big_left_q, big_left_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [1:0]    result_q, result_d;
    logic          win_q, win_d;

    logic [99:0]   center;
    logic [99:0]   mark;
    logic          x_bad, y_bad, fired, wrong;

    // Board cells are 1-based; neighbours outside 1..10 simply never match, so no wrap-around.
    always_comb begin
        center = '0;
        mark   = '0;
        for (int r = 1; r <= 10; r++) begin
            for (int c = 1; c <= 10; c++) begin
                center[(r-1)*10 + (c-1)] = (r == int'(y_q)) && (c == int'(x_q));
                if (big_q)
                    mark[(r-1)*10 + (c-1)] = (r >= int'(y_q) - 1) && (r <= int'(y_q) + 1) &&
                                             (c >= int'(x_q) - 1) && (c <= int'(x_q) + 1);
                else
                    mark[(r-1)*10 + (c-1)] = (r == int'(y_q)) && (c == int'(x_q));
            end
        end
    end

    assign x_bad = (x_q == 4'd0) || (x_q > 4'd10);
    assign y_bad = (y_q == 4'd0) || (y_q > 4'd10);
    assign fired = |(map_q & center);
    assign wrong = (state_q == SCORE) &&
                   (x_bad || y_bad || fired || (big_q && (big_left_q == '0)));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        big_d      = big_q;
        map_d      = map_q;
        shots_d    = shots_q;
        big_left_d = big_left_q;
        hits_d     = hits_q;
        result_d   = result_q;
        win_d      = win_q;
        case (state_q)
            IDLE: begin
                if (Fire) begin
                    x_d     = X_in;
                    y_d     = Y_in;
                    big_d   = BigReq;
                    state_d = SCORE;
                end
            end
            SCORE: begin
                if (wrong) begin
                    result_d = 2'b00;
                    state_d  = IDLE;
                end else begin
                    shots_d = shots_q - SW'(1);
                    if (big_q)
                        big_left_d = big_left_q - BW'(1);
                    map_d = map_q | mark;
                    if (Hit)
                        result_d = 2'b11;
                    else if (NearMiss)
                        result_d = 2'b10;
                    else
                        result_d = 2'b01;
                    if (Hit && (hits_q < HW'(HITS_TO_WIN)))
                        hits_d = hits_q + HW'(1);
                    // Reaching the hit target wins even when it coincides with the last shot.
                    if (hits_d == HW'(HITS_TO_WIN)) begin
                        state_d = OVER;
                        win_d   = 1'b1;
                    end else if (shots_d == '0) begin
                        state_d = OVER;
                        win_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            big_q      <= 1'b0;
            map_q      <= '0;
            shots_q    <= SW'(MAX_SHOTS);
            big_left_q <= BW'(MAX_BIG);
            hits_q     <= '0;
            result_q   <= 2'b00;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            big_q      <= big_d;
            map_q      <= map_d;
            shots_q    <= shots_d;
            big_left_q <= big_left_d;
            hits_q     <= hits_d;
            result_q   <= result_d;
            win_q      <= win_d;
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign Big       = big_q;
    assign ScoreThis = (state_q == SCORE);
    assign Wrong     = wrong;
    assign ShotsLeft = shots_q;
    assign BigLeft   = big_left_q;
    assign HitCount  = hits_q;
    assign Result    = result_q;
    assign GameOver  = (state_q == OVER);
    assign Win       = win_q;

endmodule

// File: tb/tb_shot_controller.sv
// Scoreboard bench for shot_controller: each Fire pushes the expected request,
// a negedge monitor pops and compares whenever ScoreThis is presented.
module tb_shot_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] X_in = '0, Y_in = '0;
    logic       BigReq = 1'b0, Fire = 1'b0, Hit = 1'b0, NearMiss = 1'b0, Miss = 1'b0;
    logic [3:0] X, Y;
    logic       Big, ScoreThis, Wrong, GameOver, Win;
    logic [4:0] ShotsLeft;
    logic [1:0] BigLeft;
    logic [2:0] HitCount;
    logic [1:0] Result;

    localparam logic [2:0] R_HIT  = 3'b100;
    localparam logic [2:0] R_NEAR = 3'b010;
    localparam logic [2:0] R_MISS = 3'b001;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       big;
        logic       wrong;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    shot_controller dut (
        .clock(clock), .reset(reset), .X_in(X_in), .Y_in(Y_in), .BigReq(BigReq),
        .Fire(Fire), .Hit(Hit), .NearMiss(NearMiss), .Miss(Miss),
        .X(X), .Y(Y), .Big(Big), .ScoreThis(ScoreThis), .Wrong(Wrong),
        .ShotsLeft(ShotsLeft), .BigLeft(BigLeft), .HitCount(HitCount),
        .Result(Result), .GameOver(GameOver), .Win(Win)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (ScoreThis) begin
                chk("scorethis_back_to_back", int'(prev), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scorethis: got request X=%0d Y=%0d required none", X, Y);
                end else begin
                    e = q.pop_front();
                    chk("req_x", int'(X), int'(e.x));
                    chk("req_y", int'(Y), int'(e.y));
                    chk("req_big", int'(Big), int'(e.big));
                    chk("req_wrong", int'(Wrong), int'(e.wrong));
                end
            end else begin
                chk("wrong_without_scorethis", int'(Wrong), 0);
            end
            prev = ScoreThis;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic shot(input int x, input int y, input bit big, input logic [2:0] resp,
                        input bit wr, input bit refire = 1'b0);
        exp_t e;
        @(negedge clock);
        X_in   = x[3:0];
        Y_in   = y[3:0];
        BigReq = big;
        Fire   = 1'b1;
        e.x = x[3:0]; e.y = y[3:0]; e.big = big; e.wrong = wr;
        q.push_back(e);
        @(negedge clock);
        Fire = refire;
        {Hit, NearMiss, Miss} = resp;
        chk("fire_to_scorethis_latency", int'(ScoreThis), 1);
        @(negedge clock);
        Fire = 1'b0;
        {Hit, NearMiss, Miss} = 3'b000;
    endtask

    task automatic fire_ignored();
        @(negedge clock);
        Fire = 1'b1;
        @(negedge clock);
        Fire = 1'b0;
        chk("ignored_fire_no_strobe", int'(ScoreThis), 0);
        @(negedge clock);
        chk("ignored_fire_no_strobe_late", int'(ScoreThis), 0);
    endtask

    task automatic status(input string tag, input int shots, input int bigs, input int hits,
                          input int res, input int go, input int win);
        chk({tag, "_shots"}, int'(ShotsLeft), shots);
        chk({tag, "_big"}, int'(BigLeft), bigs);
        chk({tag, "_hits"}, int'(HitCount), hits);
        chk({tag, "_result"}, int'(Result), res);
        chk({tag, "_gameover"}, int'(GameOver), go);
        chk({tag, "_win"}, int'(Win), win);
    endtask

    initial begin
        do_reset();
        status("reset", 20, 3, 0, 0, 0, 0);
        chk("reset_x", int'(X), 0);
        chk("reset_scorethis", int'(ScoreThis), 0);

        shot(3, 4, 0, R_NEAR, 0);
        status("near", 19, 3, 0, 2, 0, 0);

        do_reset();
        shot(0, 5, 0, R_MISS, 1);
        status("x_zero", 20, 3, 0, 0, 0, 0);
        shot(11, 2, 0, R_MISS, 1);
        status("x_eleven", 20, 3, 0, 0, 0, 0);
        shot(2, 2, 0, R_MISS, 0);
        status("fresh_2_2", 19, 3, 0, 1, 0, 0);
        shot(2, 2, 0, R_HIT, 1);
        status("repeat_2_2", 19, 3, 0, 0, 0, 0);
        shot(5, 5, 0, R_MISS, 0, 1'b1);
        status("fire_in_score", 18, 3, 0, 1, 0, 0);
        chk("x_holds", int'(X), 5);

        do_reset();
        shot(1, 1, 1, R_MISS, 0);
        status("big_corner", 19, 2, 0, 1, 0, 0);
        shot(2, 2, 0, R_MISS, 1);
        shot(1, 2, 0, R_MISS, 1);
        shot(3, 3, 0, R_MISS, 0);
        shot(10, 2, 0, R_NEAR, 0);
        status("after_clip", 17, 2, 0, 2, 0, 0);

        do_reset();
        shot(2, 2, 1, R_MISS, 0);
        shot(5, 5, 1, R_MISS, 0);
        shot(8, 8, 1, R_MISS, 0);
        shot(2, 8, 1, R_MISS, 1);
        status("big_exhausted", 17, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 5; i++) shot(2 * i + 1, 1, 0, R_HIT, 0);
        status("five_hits", 15, 3, 5, 3, 1, 1);
        fire_ignored();
        status("over_hold", 15, 3, 5, 3, 1, 1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 0) shot(1, 1, 0, 3'b111, 0);
            else if (i == 1) shot(2, 1, 0, 3'b000, 0);
            else shot(i % 10 + 1, i / 10 + 1, 0, R_MISS, 0);
            if (i == 0) status("priority", 19, 3, 1, 3, 0, 0);
            if (i == 1) status("no_response", 18, 3, 1, 1, 0, 0);
            if (i == 18) status("one_left", 1, 3, 1, 1, 0, 0);
        end
        status("out_of_shots", 0, 3, 1, 1, 1, 0);
        fire_ignored();

        do_reset();
        for (int i = 0; i < 20; i++) begin
            shot(i % 10 + 1, i / 10 + 1, 0, (i >= 15) ? R_HIT : R_MISS, 0);
            if (i == 18) status("pre_last", 1, 3, 4, 3, 0, 0);
        end
        status("win_on_last", 0, 3, 5, 3, 1, 1);

        do_reset();
        shot(4, 4, 1, R_HIT, 0);
        status("pre_abort", 19, 2, 1, 3, 0, 0);
        begin
            exp_t e;
            @(negedge clock);
            X_in = 4'd6; Y_in = 4'd6; BigReq = 1'b0; Fire = 1'b1;
            e.x = 4'd6; e.y = 4'd6; e.big = 1'b0; e.wrong = 1'b0;
            q.push_back(e);
            @(negedge clock);
            Fire = 1'b0;
            Hit = 1'b1;
            reset = 1'b1;
            chk("abort_in_score", int'(ScoreThis), 1);
            @(negedge clock);
            Hit = 1'b0;
            reset = 1'b0;
            status("abort", 20, 3, 0, 0, 0, 0);
            chk("abort_x", int'(X), 0);
            chk("abort_scorethis", int'(ScoreThis), 0);
        end
        shot(4, 4, 1, R_MISS, 0);
        status("map_cleared", 19, 2, 0, 1, 0, 0);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
